// File: rtl/regwrite_arbiter_pkg.sv
// Shared register codes, widths and arbitration types for the register-file
// writeback path.
package regwrite_arbiter_pkg;

  localparam int REG_SEL_W   = 4;
  localparam int REG_DATA_W  = 16;
  localparam int QUEUE_DEPTH = 2;

  localparam logic [REG_SEL_W-1:0] REG_ZERO = 4'd0;
  localparam logic [REG_SEL_W-1:0] REG_ONE  = 4'd1;
  localparam logic [REG_SEL_W-1:0] REG_R0   = 4'd2;
  localparam logic [REG_SEL_W-1:0] REG_R1   = 4'd3;
  localparam logic [REG_SEL_W-1:0] REG_R2   = 4'd4;
  localparam logic [REG_SEL_W-1:0] REG_R3   = 4'd5;

  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_MEM = 1'b1
  } pref_e;

  // Constant registers: writes to them are accepted but have no effect.
  function automatic logic is_sink_sel(input logic [REG_SEL_W-1:0] sel);
    return (sel == REG_ZERO) || (sel == REG_ONE);
  endfunction

endpackage

// File: rtl/regwrite_arbiter_wb_queue.sv
// Small FIFO of pending register writes with a head view and an
// "any entry targets this register" lookup used for ID stall decisions.
module regwrite_arbiter_wb_queue
  import regwrite_arbiter_pkg::*;
#(
  parameter int SEL_W  = REG_SEL_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int DEPTH  = QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [SEL_W-1:0]  push_sel,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              ready,
  output logic              nonempty,
  output logic [SEL_W-1:0]  head_sel,
  output logic [DATA_W-1:0] head_data,
  input  logic [SEL_W-1:0]  query_sel,
  output logic              query_match
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SEL_W-1:0]  sel_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [DEPTH-1:0]  entry_hit;

  assign ready     = count_reg < (PTR_W+1)'(DEPTH);
  assign nonempty  = count_reg != '0;
  assign head_sel  = sel_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr_reg]  <= push_sel;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      assign age = PTR_W'(gi) - rd_ptr_reg;
      assign entry_hit[gi] = ({1'b0, age} < count_reg) && (sel_mem[gi] == query_sel);
    end
  endgenerate

  assign query_match = |entry_hit;

endmodule

// File: rtl/regwrite_arbiter.sv
// Round-robin merge of ALU and load writebacks onto the single register-file
// write port, with a pending-write query for the ID stage.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int SEL_W  = REG_SEL_W,
  parameter int DEPTH  = QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_in,
  output logic              alu_ready_out,
  input  logic [SEL_W-1:0]  alu_sel_in,
  input  logic [DATA_W-1:0] alu_data_in,
  input  logic              mem_valid_in,
  output logic              mem_ready_out,
  input  logic [SEL_W-1:0]  mem_sel_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              setwrite_out,
  output logic [SEL_W-1:0]  sel_regwrite_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [SEL_W-1:0]  query_sel_in,
  output logic              query_pending_out
);

  logic              alu_push, mem_push;
  logic              alu_nonempty, mem_nonempty;
  logic [SEL_W-1:0]  alu_head_sel, mem_head_sel;
  logic [DATA_W-1:0] alu_head_data, mem_head_data;
  logic              alu_match, mem_match;
  logic              grant_alu, grant_mem;
  pref_e             pref_reg;
  logic              setwrite_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [DATA_W-1:0] data_reg;

  // Sink-register writes complete the handshake but are never stored.
  assign alu_push = alu_valid_in && alu_ready_out && !is_sink_sel(alu_sel_in);
  assign mem_push = mem_valid_in && mem_ready_out && !is_sink_sel(mem_sel_in);

  regwrite_arbiter_wb_queue #(.SEL_W(SEL_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_alu_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (alu_push),
    .push_sel    (alu_sel_in),
    .push_data   (alu_data_in),
    .pop         (grant_alu),
    .ready       (alu_ready_out),
    .nonempty    (alu_nonempty),
    .head_sel    (alu_head_sel),
    .head_data   (alu_head_data),
    .query_sel   (query_sel_in),
    .query_match (alu_match)
  );

  regwrite_arbiter_wb_queue #(.SEL_W(SEL_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (mem_push),
    .push_sel    (mem_sel_in),
    .push_data   (mem_data_in),
    .pop         (grant_mem),
    .ready       (mem_ready_out),
    .nonempty    (mem_nonempty),
    .head_sel    (mem_head_sel),
    .head_data   (mem_head_data),
    .query_sel   (query_sel_in),
    .query_match (mem_match)
  );

  // Same-register conflict favours the load so the ALU value lands last.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_nonempty && mem_nonempty) begin
      if (alu_head_sel == mem_head_sel) grant_mem = 1'b1;
      else if (pref_reg == PREF_MEM)    grant_mem = 1'b1;
      else                              grant_alu = 1'b1;
    end else begin
      grant_alu = alu_nonempty;
      grant_mem = mem_nonempty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_reg     <= PREF_ALU;
      setwrite_reg <= 1'b0;
      sel_reg      <= '0;
      data_reg     <= '0;
    end else begin
      setwrite_reg <= grant_alu || grant_mem;
      if (grant_alu) begin
        pref_reg <= PREF_MEM;
        sel_reg  <= alu_head_sel;
        data_reg <= alu_head_data;
      end else if (grant_mem) begin
        pref_reg <= PREF_ALU;
        sel_reg  <= mem_head_sel;
        data_reg <= mem_head_data;
      end
    end
  end

  assign setwrite_out     = setwrite_reg;
  assign sel_regwrite_out = sel_reg;
  assign data_out         = data_reg;

  assign query_pending_out = !is_sink_sel(query_sel_in) &&
                             (alu_match || mem_match ||
                              (setwrite_reg && (sel_reg == query_sel_in)));

endmodule
